// File: rtl/iob_timer_alarm_pkg.sv
// iob_timer_alarm_pkg: state encoding shared by the alarm stage and its users
package iob_timer_alarm_pkg;
  localparam int IOB_TIMER_ALARM_STATE_W = 2;
  typedef enum logic [IOB_TIMER_ALARM_STATE_W-1:0] {
    IOB_TIMER_ALARM_IDLE  = 2'd0,
    IOB_TIMER_ALARM_ARMED = 2'd1,
    IOB_TIMER_ALARM_DONE  = 2'd2,
    IOB_TIMER_ALARM_ILL   = 2'd3
  } state_t;
endpackage

// File: rtl/iob_timer_alarm_cmp.sv
// iob_timer_alarm_cmp: wrap-safe "count has reached compare" check via signed difference
module iob_timer_alarm_cmp #(
  parameter int W = 64
) (
  input  logic [W-1:0] count_i,
  input  logic [W-1:0] cmp_i,
  output logic         match_o
);
  logic [W-1:0] diff;
  assign diff    = count_i - cmp_i;
  assign match_o = ~diff[W-1];
endmodule

// File: rtl/iob_timer_alarm.sv
// iob_timer_alarm: one-shot/periodic compare alarm with sticky irq and saturating fire count
module iob_timer_alarm
  import iob_timer_alarm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                               clk_i,
  input  logic                               cke_i,
  input  logic                               arst_n_i,
  input  logic [2*DATA_W-1:0]                count_i,
  input  logic [2*DATA_W-1:0]                cmp_i,
  input  logic [DATA_W-1:0]                  period_i,
  input  logic                               periodic_i,
  input  logic                               arm_i,
  input  logic                               disarm_i,
  input  logic                               irq_clr_i,
  output logic                               irq_o,
  output logic [DATA_W-1:0]                  fire_cnt_o,
  output logic [IOB_TIMER_ALARM_STATE_W-1:0] state_o
);
  state_t              state, state_nx;
  logic [2*DATA_W-1:0] cmp_r;
  logic [DATA_W-1:0]   per_r;
  logic                mode_r, match, fire, reload, load;
  iob_timer_alarm_cmp #(.W(2*DATA_W)) u_cmp (
    .count_i (count_i),
    .cmp_i   (cmp_r),
    .match_o (match)
  );
  assign state_o = state;
  // next state: disarm beats arm beats match; the illegal code always falls back to idle
  always_comb begin
    load     = arm_i && !disarm_i && state != IOB_TIMER_ALARM_ILL;
    fire     = state == IOB_TIMER_ALARM_ARMED && match && !disarm_i && !arm_i;
    reload   = fire && mode_r && per_r != '0;
    state_nx = disarm_i || state == IOB_TIMER_ALARM_ILL ? IOB_TIMER_ALARM_IDLE :
               arm_i                                    ? IOB_TIMER_ALARM_ARMED :
               fire && !reload                          ? IOB_TIMER_ALARM_DONE : state;
  end
  // state, configuration, sticky irq and saturating fire counter, all gated by the clock enable
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state      <= IOB_TIMER_ALARM_IDLE;
      cmp_r      <= '0;
      per_r      <= '0;
      mode_r     <= 1'b0;
      irq_o      <= 1'b0;
      fire_cnt_o <= '0;
    end else if (cke_i) begin
      state <= state_nx;
      irq_o <= fire || (irq_o && !irq_clr_i);
      if (load) begin
        cmp_r      <= cmp_i;
        per_r      <= period_i;
        mode_r     <= periodic_i;
        fire_cnt_o <= '0;
      end else begin
        if (reload) cmp_r <= cmp_r + {{DATA_W{1'b0}}, per_r};
        if (fire && !(&fire_cnt_o)) fire_cnt_o <= fire_cnt_o + 1'b1;
      end
    end
  end
endmodule
